// File: rtl/image_frame_sequencer.sv
// Frame-level controller: streams a frame from memory through the image pipeline, tags in-flight pixels,
// and buffers the pipeline results onto a valid/ready output with start-of-frame / end-of-line markers.
module image_frame_sequencer #(
    parameter int unsigned IMG_W      = 64,
    parameter int unsigned IMG_H      = 64,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned PIPE_LAT   = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        cfg_threshold,
    input  logic [7:0]        cfg_brightness,
    input  logic [2:0]        cfg_select,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_rdata,
    output logic [7:0]        pix_r,
    output logic [7:0]        pix_g,
    output logic [7:0]        pix_b,
    output logic [7:0]        threshold_val,
    output logic [7:0]        brightness_offset,
    output logic [2:0]        select,
    input  logic [7:0]        proc_pixel,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol
);
    localparam int unsigned TOTAL = IMG_W * IMG_H;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned IF_W  = $clog2(PIPE_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_CFG,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W:0]     issued;
    logic [COL_W-1:0]    col;
    logic [ADDR_W-1:0]   addr_hold;
    logic [PIPE_LAT-1:0] tag_vld;
    logic [PIPE_LAT-1:0] tag_sof;
    logic [PIPE_LAT-1:0] tag_eol;
    logic [IF_W-1:0]     inflight;
    logic [CNT_W-1:0]    fifo_count;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [9:0]          fifo_mem [FIFO_DEPTH];
    logic                issue;
    logic                last_issue;
    logic                push;
    logic                pop;

    assign pix_r = mem_rdata[23:16];
    assign pix_g = mem_rdata[15:8];
    assign pix_b = mem_rdata[7:0];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(PIPE_LAT); i++) begin
            inflight = inflight + IF_W'(tag_vld[i]);
        end
    end

    // Credit check: every outstanding read already owns a FIFO slot, so a push never finds it full.
    assign issue      = (state == S_STREAM) && (issued < (ADDR_W+1)'(TOTAL))
                        && ((32'(fifo_count) + 32'(inflight)) < FIFO_DEPTH);
    assign last_issue = issue && (issued == (ADDR_W+1)'(TOTAL - 1));
    assign mem_rd_en  = issue;
    assign mem_addr   = issue ? issued[ADDR_W-1:0] : addr_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (start) state_next = S_LOAD_CFG;
            S_LOAD_CFG: state_next = S_STREAM;
            S_STREAM:   if (last_issue) state_next = S_DRAIN;
            S_DRAIN:    if (inflight == '0 && fifo_count == '0) state_next = S_DONE;
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Status and frame-latched configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy              <= 1'b0;
            done              <= 1'b0;
            threshold_val     <= '0;
            brightness_offset <= '0;
            select            <= '0;
        end else begin
            busy <= (state_next != S_IDLE);
            done <= (state_next == S_DONE);
            if (state == S_IDLE && start) begin
                threshold_val     <= cfg_threshold;
                brightness_offset <= cfg_brightness;
                select            <= cfg_select;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued    <= '0;
            col       <= '0;
            addr_hold <= '0;
        end else if (state == S_LOAD_CFG) begin
            issued <= '0;
            col    <= '0;
        end else if (issue) begin
            issued    <= issued + (ADDR_W+1)'(1);
            addr_hold <= issued[ADDR_W-1:0];
            col       <= (col == COL_W'(IMG_W - 1)) ? '0 : col + COL_W'(1);
        end
    end

    // Tag pipe mirrors the memory + pipeline latency so results know their frame position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld <= '0;
            tag_sof <= '0;
            tag_eol <= '0;
        end else begin
            tag_vld[0] <= issue;
            tag_sof[0] <= (issued == '0);
            tag_eol[0] <= (col == COL_W'(IMG_W - 1));
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_sof[i] <= tag_sof[i-1];
                tag_eol[i] <= tag_eol[i-1];
            end
        end
    end

    assign push = tag_vld[PIPE_LAT-1];
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {tag_sof[PIPE_LAT-1], tag_eol[PIPE_LAT-1], proc_pixel};
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_mem[rd_ptr][7:0];
    assign out_sof   = fifo_mem[rd_ptr][9];
    assign out_eol   = fifo_mem[rd_ptr][8];

endmodule

// File: tb/tb_image_frame_sequencer.sv
// Bench for image_frame_sequencer: frame memory and pipeline models feed the DUT, a scoreboard queue holds
// the expected output stream and a negedge monitor pops and compares every accepted pixel.
module tb_image_frame_sequencer;
    localparam int unsigned IMG_W      = 4;
    localparam int unsigned IMG_H      = 2;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned PIPE_LAT   = 2;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int          N          = IMG_W * IMG_H;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eol;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        cfg_threshold = '0;
    logic [7:0]        cfg_brightness = '0;
    logic [2:0]        cfg_select = '0;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [23:0]       mem_rdata = '0;
    logic [7:0]        pix_r;
    logic [7:0]        pix_g;
    logic [7:0]        pix_b;
    logic [7:0]        threshold_val;
    logic [7:0]        brightness_offset;
    logic [2:0]        select;
    logic [7:0]        proc_pixel = '0;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_sof;
    logic              out_eol;

    int   checks = 0;
    int   errors = 0;
    int   out_cnt = 0;
    int   done_cnt = 0;
    int   issue_cnt = 0;
    int   exp_addr = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    image_frame_sequencer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_threshold(cfg_threshold), .cfg_brightness(cfg_brightness), .cfg_select(cfg_select),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .threshold_val(threshold_val), .brightness_offset(brightness_offset), .select(select),
        .proc_pixel(proc_pixel), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eol(out_eol)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] mem_word(input int i);
        return {8'(i * 7 + 3), 8'(i * 13 + 1), 8'(255 - i)};
    endfunction

    function automatic logic [7:0] pix_fn(input logic [23:0] d);
        return d[23:16] ^ (d[15:8] >> 1) ^ d[7:0];
    endfunction

    // One-cycle memory followed by one pipeline register.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem_word(int'(mem_addr));
        proc_pixel <= pix_fn({pix_r, pix_g, pix_b});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_addr = 0;
        end else begin
            if (mem_rd_en) begin
                check("mem_addr", 32'(mem_addr), 32'(exp_addr));
                exp_addr = (exp_addr + 1) % N;
                issue_cnt++;
            end
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                out_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%0h required=none", out_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("out_data", 32'(out_data), 32'(mon_e.data));
                    check("out_sof", 32'(out_sof), 32'(mon_e.sof));
                    check("out_eol", 32'(out_eol), 32'(mon_e.eol));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [7:0] thr, input logic [7:0] bri, input logic [2:0] sel);
        exp_t e;
        cfg_threshold  = thr;
        cfg_brightness = bri;
        cfg_select     = sel;
        for (int i = 0; i < N; i++) begin
            e.data = pix_fn(mem_word(i));
            e.sof  = (i == 0);
            e.eol  = ((i % IMG_W) == IMG_W - 1);
            sb_q.push_back(e);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd, input int max_cyc);
        bit ok = 1'b0;
        for (int c = 0; c < max_cyc && !ok; c++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
            else begin
                tick();
                if (rnd) out_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done_within_%0d", max_cyc);
        end
    endtask

    task automatic wait_issue(input int addr);
        bit ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (mem_rd_en && int'(mem_addr) == addr) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout actual=no_read required=addr_%0d", addr);
        end
    endtask

    task automatic end_frame(input int d0, input int o0);
        repeat (3) tick();
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("frame_outputs", 32'(out_cnt - o0), 32'(N));
        check("busy_after", 32'(busy), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int d0;
        int o0;
        int i0;
        logic [7:0] held;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sof_eol", 32'({out_sof, out_eol}), 32'd0);
        check("rst_cfg", 32'({threshold_val, brightness_offset, select}), 32'd0);
        rst = 1'b0;
        tick();

        // Full-rate frame: eight back-to-back reads.
        out_ready = 1'b1;
        d0 = done_cnt; o0 = out_cnt;
        start_frame(8'h80, 8'h05, 3'd2);
        check("busy_in_frame", 32'(busy), 32'd1);
        wait_issue(0);
        for (int k = 0; k < N; k++) begin
            check("t1_rd_en", 32'(mem_rd_en), 32'd1);
            check("t1_addr", 32'(mem_addr), 32'(k));
            if (k < N - 1) @(negedge clk);
        end
        wait_done(1'b0, 200);
        end_frame(d0, o0);
        check("t1_cfg", 32'({threshold_val, brightness_offset, select}), {13'd0, 8'h80, 8'h05, 3'd2});

        // Backpressure: FIFO fills to its depth, issuing stops, head holds.
        out_ready = 1'b0;
        d0 = done_cnt; o0 = out_cnt; i0 = issue_cnt;
        start_frame(8'h22, 8'hF0, 3'd5);
        repeat (14) tick();
        @(negedge clk);
        check("t2_issued", 32'(issue_cnt - i0), 32'(FIFO_DEPTH));
        check("t2_rd_en", 32'(mem_rd_en), 32'd0);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_sof", 32'(out_sof), 32'd1);
        held = pix_fn(mem_word(0));
        for (int k = 0; k < 3; k++) begin
            check("t2_hold", 32'(out_data), 32'(held));
            @(negedge clk);
        end
        check("t2_no_out", 32'(out_cnt - o0), 32'd0);
        tick();
        out_ready = 1'b1;
        wait_done(1'b0, 200);
        end_frame(d0, o0);

        // Config changes mid-frame must not reach the pipeline.
        d0 = done_cnt; o0 = out_cnt;
        start_frame(8'h80, 8'h01, 3'd1);
        repeat (3) tick();
        cfg_threshold = 8'h10;
        cfg_select = 3'd7;
        tick();
        check("t3_thr_mid", 32'(threshold_val), 32'h80);
        check("t3_sel_mid", 32'(select), 32'd1);
        wait_done(1'b0, 200);
        end_frame(d0, o0);
        check("t3_thr_after", 32'(threshold_val), 32'h80);
        d0 = done_cnt; o0 = out_cnt;
        start_frame(8'h10, 8'h01, 3'd7);
        repeat (2) tick();
        check("t3_thr_new", 32'(threshold_val), 32'h10);
        wait_done(1'b0, 200);
        end_frame(d0, o0);

        // Reset during streaming aborts the frame silently.
        d0 = done_cnt;
        start_frame(8'h33, 8'h44, 3'd3);
        wait_issue(3);
        #2;
        rst = 1'b1;
        #1;
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_rd_en", 32'(mem_rd_en), 32'd0);
        check("t4_addr", 32'(mem_addr), 32'd0);
        check("t4_valid", 32'(out_valid), 32'd0);
        check("t4_cfg", 32'({threshold_val, brightness_offset, select}), 32'd0);
        sb_q.delete();
        exp_addr = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) tick();
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        check("t4_idle", 32'(busy), 32'd0);
        d0 = done_cnt; o0 = out_cnt;
        start_frame(8'h33, 8'h44, 3'd3);
        wait_done(1'b0, 200);
        end_frame(d0, o0);

        // A second start while busy is ignored.
        d0 = done_cnt; o0 = out_cnt;
        start_frame(8'h01, 8'h02, 3'd4);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b0, 200);
        end_frame(d0, o0);

        // Random backpressure across three frames.
        for (int f = 0; f < 3; f++) begin
            d0 = done_cnt; o0 = out_cnt;
            start_frame(8'($urandom), 8'($urandom), 3'($urandom));
            wait_done(1'b1, 2000);
            out_ready = 1'b1;
            end_frame(d0, o0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
